// File: rtl/hw1_func_sweep.sv
// rtl/hw1_func_sweep.sv - exhaustive truth-table sweep of a 4-input combinational function
// Drives every {a,b,c,d} vector, waits SETTLE_CYCLES per vector, and records f_in.
module hw1_func_sweep #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  ones_count
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

  state_e      state;
  state_e      nextState;
  logic [3:0]  index;
  logic [7:0]  settleCnt;
  logic [15:0] ttReg;
  logic [4:0]  onesReg;
  logic        sampleNow;

  assign sampleNow = (state == SWEEP) && (settleCnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = SWEEP;
      SWEEP:   if (sampleNow && (index == 4'd15)) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The index is never wrapped, so it keeps the last vector on the pins once idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index     <= 4'd0;
      settleCnt <= 8'd0;
      ttReg     <= 16'h0000;
      onesReg   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            index     <= 4'd0;
            settleCnt <= 8'd0;
            ttReg     <= 16'h0000;
            onesReg   <= 5'd0;
          end
        end
        SWEEP: begin
          if (sampleNow) begin
            ttReg[index] <= f_in;
            onesReg      <= onesReg + {4'd0, f_in};
            settleCnt    <= 8'd0;
            if (index != 4'd15) index <= index + 4'd1;
          end else begin
            settleCnt <= settleCnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign {a, b, c, d} = index;
  assign busy         = (state == SWEEP);
  assign done         = (state == DONE);
  assign truth_table  = ttReg;
  assign ones_count   = onesReg;

endmodule

// File: tb/tb_hw1_func_sweep.sv
// tb/tb_hw1_func_sweep.sv - scoreboard bench for hw1_func_sweep at SETTLE_CYCLES 4 and 1
module tb_hw1_func_sweep;

  typedef struct {
    int          dut;
    logic [15:0] tt;
    logic [4:0]  ones;
    int          startEdge;
    int          settle;
  } sbItem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start4 = 1'b0;
  logic        start1 = 1'b0;
  int          mode = 0;
  logic [15:0] randTbl = 16'h0000;
  int          cyc = 0;
  int          nChecks = 0;
  int          nFails = 0;
  sbItem       sbQ[$];

  logic        a4, b4, c4, d4, busy4, done4, fIn4, hw1Slow4;
  logic [15:0] tt4;
  logic [4:0]  ones4;
  logic        a1, b1, c1, d1, busy1, done1, fIn1;
  logic [15:0] tt1;
  logic [4:0]  ones1;
  logic [3:0]  vec4, vec1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the HW1 function: F = A&~B | B&C&~D | ~A&D
  function automatic logic hw1(input logic [3:0] v);
    return (v[3] & ~v[2]) | (v[2] & v[1] & ~v[0]) | (~v[3] & v[0]);
  endfunction

  function automatic logic fModel(input int m, input logic [3:0] v, input logic [15:0] tbl);
    case (m)
      0:       return v[3];
      1:       return ^v;
      2:       return 1'b1;
      3:       return hw1(v);
      default: return tbl[v];
    endcase
  endfunction

  function automatic logic [15:0] expTT(input int m, input logic [15:0] tbl);
    logic [15:0] r;
    r = 16'h0000;
    case (m)
      0:       r = 16'hFF00;
      1:       r = 16'h6996;
      2:       r = 16'hFFFF;
      default: for (int i = 0; i < 16; i++) r[i] = fModel(m, 4'(i), tbl);
    endcase
    return r;
  endfunction

  assign vec4 = {a4, b4, c4, d4};
  assign vec1 = {a1, b1, c1, d1};
  assign #30 hw1Slow4 = hw1(vec4);
  assign fIn4 = (mode == 3) ? hw1Slow4 : fModel(mode, vec4, randTbl);
  assign fIn1 = fModel(mode, vec1, randTbl);

  hw1_func_sweep #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .f_in(fIn4),
    .a(a4), .b(b4), .c(c4), .d(d4), .busy(busy4), .done(done4),
    .truth_table(tt4), .ones_count(ones4)
  );

  hw1_func_sweep #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .f_in(fIn1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .truth_table(tt1), .ones_count(ones1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic pushExp(input int dut, input int m, input int startEdge);
    sbItem it;
    it.dut       = dut;
    it.tt        = expTT(m, randTbl);
    it.ones      = 5'($countones(it.tt));
    it.startEdge = startEdge;
    it.settle    = (dut == 0) ? 4 : 1;
    sbQ.push_back(it);
  endtask

  task automatic waitDrain(input int bound);
    for (int i = 0; i < bound && sbQ.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    nChecks++;
    if (sbQ.size() > 0) begin
      nFails++;
      $display("FAIL done_timeout actual=%0d pending required=0 pending", sbQ.size());
      sbQ.delete();
    end
  endtask

  task automatic runSweep(input int dut, input int m);
    @(negedge clk);
    mode = m;
    pushExp(dut, m, cyc + 1);
    if (dut == 0) start4 = 1'b1;
    else          start1 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    start1 = 1'b0;
    waitDrain((dut == 0) ? 80 : 30);
  endtask

  // Monitor: busy window and done results come only from the scoreboard head.
  always @(negedge clk) begin
    logic  expB4, expB1, inWin;
    sbItem it;
    expB4 = 1'b0;
    expB1 = 1'b0;
    if (sbQ.size() > 0) begin
      inWin = (cyc >= sbQ[0].startEdge) && (cyc < sbQ[0].startEdge + 16 * sbQ[0].settle);
      if (sbQ[0].dut == 0) expB4 = inWin;
      else                 expB1 = inWin;
    end
    check("busy", 32'({busy4, busy1}), 32'({expB4, expB1}));
    if (done4 || done1) begin
      if (sbQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL unexpected_done actual=%b%b required=00", done4, done1);
      end else begin
        it = sbQ.pop_front();
        check("done_which", 32'({done4, done1}), (it.dut == 0) ? 32'd2 : 32'd1);
        check("truth_table", 32'((it.dut == 0) ? tt4 : tt1), 32'(it.tt));
        check("ones_count", 32'((it.dut == 0) ? ones4 : ones1), 32'(it.ones));
        check("done_latency", 32'(cyc - it.startEdge), 32'(16 * it.settle));
      end
    end
  end

  initial begin
    int s;
    #2 rst_n = 1'b0;
    #1;
    check("reset_dut4", 32'({vec4, busy4, done4, tt4, ones4}), 32'd0);
    check("reset_dut1", 32'({vec1, busy1, done1, tt1, ones1}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    runSweep(0, 0);
    runSweep(0, 1);
    runSweep(0, 2);
    runSweep(0, 3);
    for (int k = 0; k < 3; k++) begin
      randTbl = 16'($urandom);
      runSweep(0, 4);
    end

    // Abort a sweep two cycles into vector 7, between clock edges.
    @(negedge clk);
    mode = 4;
    randTbl = 16'($urandom);
    pushExp(0, 4, cyc + 1);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 60 && vec4 != 4'd7; i++) @(negedge clk);
    check("reach_vec7", 32'(vec4), 32'd7);
    @(negedge clk);
    #2 rst_n = 1'b0;
    sbQ.delete();
    #1;
    check("abort_outputs", 32'({vec4, busy4, done4}), 32'd0);
    check("abort_results", 32'({tt4, ones4}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    runSweep(0, 1);

    // Start held high across a whole sweep: exactly one restart after IDLE.
    @(negedge clk);
    mode = 1;
    s = cyc + 1;
    pushExp(0, 1, s);
    pushExp(0, 0, s + 66);
    start4 = 1'b1;
    for (int i = 0; i < 200 && cyc < s + 66; i++) begin
      @(negedge clk);
      if (cyc == s + 64) mode = 0;
    end
    start4 = 1'b0;
    waitDrain(80);

    runSweep(1, 0);
    runSweep(1, 2);
    runSweep(1, 1);
    for (int k = 0; k < 3; k++) begin
      randTbl = 16'($urandom);
      runSweep(1, 4);
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/hw1_func_sweep.md
HW1_FUNC_SWEEP -- requirements
Module: hw1_func_sweep

Interface
REQ-001 The block SHALL have one clock, clk; reset SHALL be asynchronous and active-low, named rst_n.
REQ-002 Parameter SETTLE_CYCLES, default 4, SHALL set the clock cycles each input vector is held before f_in is sampled; legal range 1..255.
REQ-003 Ports SHALL be, one per line:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  sweep request, sampled in IDLE only
- f_in  input  1  response F of the 4-input combinational function under test
- a  output  1  input A to the function (vector MSB)
- b  output  1  input B
- c  output  1  input C
- d  output  1  input D (vector LSB)
- busy  output  1  high while sweeping
- done  output  1  one-cycle completion pulse
- truth_table  output  16  captured F; bit i = F at {A,B,C,D}=i
- ones_count  output  5  number of captured 1s, 0..16

Function
REQ-004 The FSM SHALL have the states IDLE, SWEEP and DONE.
REQ-005 IDLE -> SWEEP on the rising edge where start=1; on that edge: index=0, settle counter=0, truth_table=0, ones_count=0.
REQ-006 In SWEEP, {a,b,c,d} SHALL equal the 4-bit index, driven from registers with no combinational path from inputs.
REQ-007 The settle counter SHALL count 0..SETTLE_CYCLES-1; on the edge where it equals SETTLE_CYCLES-1, it SHALL:
- store f_in into truth_table[index]
- increment ones_count if f_in=1
- reset the counter to 0
REQ-008 On that sampling edge, index SHALL increment if below 15; if index=15, the FSM SHALL go to DONE and the index SHALL NOT wrap.
REQ-009 Each vector SHALL be held for exactly SETTLE_CYCLES cycles. With the start edge at E0, the sampling edges SHALL be E0+k*SETTLE_CYCLES for k=1..16.
REQ-010 DONE SHALL last exactly one cycle with done=1, then return to IDLE. done SHALL be high at no other time.
REQ-011 busy SHALL be 1 in SWEEP and 0 in IDLE and DONE.
REQ-012 start SHALL be ignored in SWEEP and DONE; a start held high in DONE SHALL only launch a new sweep once the FSM is back in IDLE.
REQ-013 truth_table and ones_count SHALL hold their final values through DONE and IDLE until the next accepted start clears them.
REQ-014 In IDLE and DONE, {a,b,c,d} SHALL hold the last driven vector (4'b0000 after reset).
REQ-015 ones_count SHALL be 5 bits so that the value 16 does not overflow.

Reset
REQ-016 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state IDLE
- index 0, settle counter 0
- a,b,c,d = 0
- busy = 0, done = 0
- truth_table = 16'h0000, ones_count = 0
REQ-017 Reset asserted mid-sweep SHALL abort the sweep and discard partial results; after release, a new start SHALL be required and no done SHALL be produced for the aborted sweep.
REQ-018 The block SHALL leave IDLE after reset release only on a start sampled at a rising edge with rst_n=1.

Verification
REQ-019 SETTLE_CYCLES=4, f_in tied to a, start pulsed one cycle -> done high exactly 64 cycles after the start edge; truth_table=16'hFF00, ones_count=8.
REQ-020 f_in = a^b^c^d -> truth_table=16'h6996, ones_count=8; f_in tied 1 -> 16'hFFFF, ones_count=16 (no overflow).
REQ-021 f_in driven by a behavioral model of the team's HW1 function with 30 ns of combinational delay, clock 10 ns, SETTLE_CYCLES=4 -> truth_table matches the model's truth table.
REQ-022 rst_n pulsed low at vector 7 mid-settle -> all outputs 0 asynchronously and no done pulse; a subsequent start gives a full correct sweep.
REQ-023 start held high for the whole sweep -> no restart during SWEEP; one done pulse, then a new sweep starts the cycle after returning to IDLE, with results cleared.
REQ-024 SETTLE_CYCLES=1 -> a new vector every cycle; done 16 cycles after the start edge; results match REQ-019.
